// File: rtl/bus_xfer_ctrl.sv
// bus_xfer_ctrl: sequences MOVE / LOAD_CONST / SWAP commands into
// single-driver bus cycles. It drives one-hot register load/drive strobes,
// the constant-injection select and the TMP scratch register enables.
// Every output comes straight from a flop. Each step's enables are computed
// one cycle ahead and registered on the edge that enters that step.
module bus_xfer_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 4,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [IDX_W-1:0]    cmd_src,
  input  logic [IDX_W-1:0]    cmd_dst,
  input  logic [WIDTH-1:0]    cmd_const,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                tmp_in,
  output logic                tmp_out,
  output logic                const_en,
  output logic [WIDTH-1:0]    const_val,
  output logic                done,
  output logic                err
);

  typedef enum logic [1:0] {IDLE, STEP1, STEP2, STEP3} state_t;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // One-hot strobe for a register index. Only called with indices that
  // have already been range-checked.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = NUM_REGS'(1) << idx;
  endfunction

  function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
    idx_ok = 32'(idx) < 32'(NUM_REGS);
  endfunction

  state_t              state_reg, state_next;
  logic [1:0]          op_reg, op_next;
  logic [IDX_W-1:0]    src_reg, src_next;
  logic [IDX_W-1:0]    dst_reg, dst_next;
  logic                ready_reg, ready_next;
  logic [NUM_REGS-1:0] reg_in_reg, reg_in_next;
  logic [NUM_REGS-1:0] reg_out_reg, reg_out_next;
  logic                tmp_in_reg, tmp_in_next;
  logic                tmp_out_reg, tmp_out_next;
  logic                const_en_reg, const_en_next;
  logic [WIDTH-1:0]    const_val_reg, const_val_next;
  logic                done_reg, done_next;
  logic                err_reg, err_next;

  logic cmd_bad;
  logic cmd_noop;

  // A command is rejected if it uses an out-of-range index or the reserved
  // opcode. LOAD_CONST has no source operand, so its src is not checked.
  assign cmd_bad = (cmd_op == OP_RSVD) || !idx_ok(cmd_dst) ||
                   ((cmd_op != OP_LOAD) && !idx_ok(cmd_src));

  // MOVE or SWAP of a register onto itself changes nothing. It completes at
  // once without touching the bus.
  assign cmd_noop = ((cmd_op == OP_MOVE) || (cmd_op == OP_SWAP)) &&
                    (cmd_src == cmd_dst);

  // State and registered outputs. Reset drops every enable immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      op_reg        <= OP_MOVE;
      src_reg       <= '0;
      dst_reg       <= '0;
      ready_reg     <= 1'b1;
      reg_in_reg    <= '0;
      reg_out_reg   <= '0;
      tmp_in_reg    <= 1'b0;
      tmp_out_reg   <= 1'b0;
      const_en_reg  <= 1'b0;
      const_val_reg <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      ready_reg     <= ready_next;
      reg_in_reg    <= reg_in_next;
      reg_out_reg   <= reg_out_next;
      tmp_in_reg    <= tmp_in_next;
      tmp_out_reg   <= tmp_out_next;
      const_en_reg  <= const_en_next;
      const_val_reg <= const_val_next;
      done_reg      <= done_next;
      err_reg       <= err_next;
    end
  end

  // Next state and the enables for the cycle about to start. Strobes default
  // to zero, so each one lasts exactly one cycle.
  always_comb begin
    state_next     = state_reg;
    op_next        = op_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    const_val_next = const_val_reg;
    reg_in_next    = '0;
    reg_out_next   = '0;
    tmp_in_next    = 1'b0;
    tmp_out_next   = 1'b0;
    const_en_next  = 1'b0;
    done_next      = 1'b0;
    err_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (cmd_valid && ready_reg) begin
          op_next  = cmd_op;
          src_next = cmd_src;
          dst_next = cmd_dst;
          if (cmd_bad) begin
            done_next = 1'b1;
            err_next  = 1'b1;
          end else if (cmd_noop) begin
            done_next = 1'b1;
          end else begin
            state_next = STEP1;
            case (cmd_op)
              OP_MOVE: begin
                reg_out_next = onehot(cmd_src);
                reg_in_next  = onehot(cmd_dst);
              end
              OP_LOAD: begin
                const_en_next  = 1'b1;
                const_val_next = cmd_const;
                reg_in_next    = onehot(cmd_dst);
              end
              default: begin
                // SWAP: park src in TMP first.
                reg_out_next = onehot(cmd_src);
                tmp_in_next  = 1'b1;
              end
            endcase
          end
        end
      end
      STEP1: begin
        if (op_reg == OP_SWAP) begin
          state_next   = STEP2;
          reg_out_next = onehot(dst_reg);
          reg_in_next  = onehot(src_reg);
        end else begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      STEP2: begin
        state_next   = STEP3;
        tmp_out_next = 1'b1;
        reg_in_next  = onehot(dst_reg);
      end
      STEP3: begin
        state_next = IDLE;
        done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Ready is registered alongside the state. It is high for every IDLE cycle,
  // including the done cycle, so back-to-back accepts are possible.
  always_comb begin
    ready_next = (state_next == IDLE);
  end

  assign cmd_ready = ready_reg;
  assign reg_in    = reg_in_reg;
  assign reg_out   = reg_out_reg;
  assign tmp_in    = tmp_in_reg;
  assign tmp_out   = tmp_out_reg;
  assign const_en  = const_en_reg;
  assign const_val = const_val_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl. It uses a table of commands with expected error
// flag, latency and final register values. A per-cycle scoreboard of
// expected strobes is filled at each accept. A register/TMP model follows
// the DUT's enables and the shared bus. Some hand-written sequences cover
// back-to-back accepts and reset during a SWAP.
module tb_bus_xfer_ctrl;

  localparam int NR = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_src;
  logic [3:0]  cmd_dst;
  logic [31:0] cmd_const;
  logic [7:0]  reg_in;
  logic [7:0]  reg_out;
  logic        tmp_in;
  logic        tmp_out;
  logic        const_en;
  logic [31:0] const_val;
  logic        done;
  logic        err;

  bus_xfer_ctrl #(.NUM_REGS(NR), .IDX_W(4), .WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_const(cmd_const),
    .reg_in(reg_in), .reg_out(reg_out), .tmp_in(tmp_in), .tmp_out(tmp_out),
    .const_en(const_en), .const_val(const_val), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected outputs for one clock cycle.
  typedef struct packed {
    logic [7:0]  ri;
    logic [7:0]  ro;
    logic        ti;
    logic        to;
    logic        ce;
    logic        dn;
    logic        er;
    logic        rdy;
    logic [31:0] cv;
  } exp_t;

  exp_t sb[$];
  logic [31:0] regs[NR];
  logic [31:0] tmp_reg;
  bit mon_en = 1'b0;

  function automatic exp_t blank(input logic rdy);
    exp_t e;
    e = '0;
    e.rdy = rdy;
    return e;
  endfunction

  // Queue the cycle-by-cycle output sequence the command should produce.
  task automatic push_expect(input logic [1:0] op, input logic [3:0] src,
                             input logic [3:0] dst, input logic [31:0] cv);
    bit bad, noop;
    exp_t e;
    bad  = (op == 2'b11) || (dst >= NR) || (op != 2'b01 && src >= NR);
    noop = !bad && (op != 2'b01) && (src == dst);
    if (bad || noop) begin
      e = blank(1'b1); e.dn = 1'b1; e.er = bad; sb.push_back(e);
    end else begin
      case (op)
        2'b00: begin
          e = blank(1'b0); e.ro = 8'd1 << src; e.ri = 8'd1 << dst; sb.push_back(e);
        end
        2'b01: begin
          e = blank(1'b0); e.ce = 1'b1; e.cv = cv; e.ri = 8'd1 << dst; sb.push_back(e);
        end
        default: begin
          e = blank(1'b0); e.ro = 8'd1 << src; e.ti = 1'b1; sb.push_back(e);
          e = blank(1'b0); e.ro = 8'd1 << dst; e.ri = 8'd1 << src; sb.push_back(e);
          e = blank(1'b0); e.to = 1'b1; e.ri = 8'd1 << dst; sb.push_back(e);
        end
      endcase
      e = blank(1'b1); e.dn = 1'b1; sb.push_back(e);
    end
  endtask

  // Monitor: compare each cycle against the scoreboard (idle when empty),
  // check the single-driver rule, then apply this cycle's bus transfer
  // to the register model (captured on the edge ending the cycle).
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en && !reset) begin
      exp_t e;
      logic [31:0] bus, d;
      int drivers;
      e = (sb.size() > 0) ? sb.pop_front() : blank(1'b1);
      chk("cycle_outputs",
          {reg_in, reg_out, tmp_in, tmp_out, const_en, done, err, cmd_ready},
          {e.ri, e.ro, e.ti, e.to, e.ce, e.dn, e.er, e.rdy});
      if (e.ce) chk("const_val", const_val, e.cv);
      drivers = $countones(reg_out) + int'(tmp_out) + int'(const_en);
      chk("single_driver", {63'd0, (drivers <= 1) && $onehot0(reg_in) && $onehot0(reg_out)}, 64'd1);
      bus = 32'hxxxx_xxxx;
      for (int i = 0; i < NR; i++) if (reg_out[i]) bus = regs[i];
      if (tmp_out) bus = tmp_reg;
      d = const_en ? const_val : bus;
      if (tmp_in) tmp_reg = bus;
      for (int i = 0; i < NR; i++) if (reg_in[i]) regs[i] = d;
    end
  end

  // Present a command, wait (bounded) for ready, queue its expectations,
  // and let it be accepted. Afterwards scramble the fields to show they were latched.
  task automatic issue(input logic [1:0] op, input logic [3:0] src, input logic [3:0] dst,
                       input logic [31:0] cv, output int waits);
    @(negedge clk);
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_const = cv; cmd_valid = 1'b1;
    waits = 0;
    while (!cmd_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    chk("cmd_ready_at_issue", {63'd0, cmd_ready}, 64'd1);
    push_expect(op, src, dst, cv);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_src   = 4'($urandom);
    cmd_dst   = 4'($urandom);
    cmd_const = $urandom;
  endtask

  // Count edges from the accept edge until done is seen (bounded).
  task automatic wait_done(output int lat, output logic err_seen);
    lat = 0;
    while (!done && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("done_seen", {63'd0, done}, 64'd1);
    err_seen = err;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  src;
    logic [3:0]  dst;
    logic [31:0] cv;
    logic        exp_err;
    int          exp_lat;
    int          ia;
    logic [31:0] va;
    int          ib;
    logic [31:0] vb;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int   waits, lat;
    logic e_seen;

    vecs[0]  = '{2'b01, 4'd0,  4'd0,  32'd50,       1'b0, 1, 0, 32'd50,       1, 32'd101};
    vecs[1]  = '{2'b00, 4'd0,  4'd1,  32'd0,        1'b0, 1, 0, 32'd50,       1, 32'd50};
    vecs[2]  = '{2'b01, 4'd0,  4'd0,  32'd70,       1'b0, 1, 0, 32'd70,       1, 32'd50};
    vecs[3]  = '{2'b10, 4'd0,  4'd1,  32'd0,        1'b0, 3, 0, 32'd50,       1, 32'd70};
    vecs[4]  = '{2'b00, 4'd9,  4'd1,  32'd0,        1'b1, 0, 0, 32'd50,       1, 32'd70};
    vecs[5]  = '{2'b11, 4'd0,  4'd1,  32'd0,        1'b1, 0, 0, 32'd50,       1, 32'd70};
    vecs[6]  = '{2'b00, 4'd3,  4'd3,  32'd0,        1'b0, 0, 3, 32'd103,      2, 32'd102};
    vecs[7]  = '{2'b00, 4'd2,  4'd3,  32'd0,        1'b0, 1, 3, 32'd102,      2, 32'd102};
    vecs[8]  = '{2'b01, 4'd15, 4'd7,  32'hDEADBEEF, 1'b0, 1, 7, 32'hDEADBEEF, 6, 32'd106};
    vecs[9]  = '{2'b10, 4'd2,  4'd12, 32'd0,        1'b1, 0, 2, 32'd102,      7, 32'hDEADBEEF};
    vecs[10] = '{2'b01, 4'd0,  4'd8,  32'd1,        1'b1, 0, 0, 32'd50,       1, 32'd70};
    vecs[11] = '{2'b01, 4'd4,  4'd4,  32'd5,        1'b0, 1, 4, 32'd5,        3, 32'd102};
    vecs[12] = '{2'b10, 4'd6,  4'd7,  32'd0,        1'b0, 3, 6, 32'hDEADBEEF, 7, 32'd106};

    for (int i = 0; i < NR; i++) regs[i] = 32'(100 + i);
    tmp_reg   = '0;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_const = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        {reg_in, reg_out, tmp_in, tmp_out, const_en, done, err, cmd_ready, const_val},
        {8'd0, 8'd0, 6'b000001, 32'd0});
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", {63'd0, cmd_ready}, 64'd1);
    mon_en = 1'b1;

    // Table-driven commands.
    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].op, vecs[i].src, vecs[i].dst, vecs[i].cv, waits);
      wait_done(lat, e_seen);
      $display("vec %0d: op=%0d src=%0d dst=%0d lat=%0d err=%0b", i, vecs[i].op,
               vecs[i].src, vecs[i].dst, lat, e_seen);
      chk($sformatf("vec%0d_err", i), {63'd0, e_seen}, {63'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      chk($sformatf("vec%0d_reg%0d", i, vecs[i].ia), {32'd0, regs[vecs[i].ia]}, {32'd0, vecs[i].va});
      chk($sformatf("vec%0d_reg%0d", i, vecs[i].ib), {32'd0, regs[vecs[i].ib]}, {32'd0, vecs[i].vb});
    end

    // Back-to-back: no-op MOVE, then MOVE accepted in its done cycle.
    issue(2'b00, 4'd4, 4'd4, 32'd0, waits);
    wait_done(lat, e_seen);
    chk("noop_lat", 64'(lat), 64'd0);
    issue(2'b00, 4'd0, 4'd4, 32'd0, waits);
    chk("b2b_accept_in_done_cycle", 64'(waits), 64'd0);
    wait_done(lat, e_seen);
    $display("b2b move: lat=%0d err=%0b R4=%0d", lat, e_seen, regs[4]);
    chk("b2b_lat", 64'(lat), 64'd1);
    chk("b2b_r4", {32'd0, regs[4]}, 64'd50);

    // Reset during STEP2 of SWAP 2<->5.
    issue(2'b10, 4'd2, 4'd5, 32'd0, waits);
    @(posedge clk);
    #3;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("reset_mid_enables", {48'd0, reg_in, reg_out}, 64'd0);
    chk("reset_mid_ctl", {58'd0, tmp_in, tmp_out, const_en, done, err, cmd_ready}, 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", {63'd0, cmd_ready}, 64'd1);
    chk("post_reset_no_done", {63'd0, done}, 64'd0);
    issue(2'b01, 4'd0, 4'd2, 32'd77, waits);
    wait_done(lat, e_seen);
    $display("post-reset load: lat=%0d err=%0b R2=%0d", lat, e_seen, regs[2]);
    chk("post_reset_lat", 64'(lat), 64'd1);
    chk("post_reset_err", {63'd0, e_seen}, 64'd0);
    chk("post_reset_r2", {32'd0, regs[2]}, 64'd77);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
- Control-side counterpart to the shared-bus register file: generates the per-register in/out enables that the register instances consume.
- Accepts one transfer command at a time (MOVE, LOAD_CONST, SWAP) over a valid/ready handshake and sequences it into single-driver bus cycles.
- Sits between the future instruction decoder and the register array; drives one-hot read/write strobes, a constant-injection mux select and a scratch (TMP) register's enables.

Parameters:
- NUM_REGS, 8, number of general registers on the bus (2..16)
- IDX_W, 4, width of register index fields
- WIDTH, 32, data/bus width (constant path only)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  2  00 MOVE, 01 LOAD_CONST, 10 SWAP, 11 reserved
- cmd_src  input  IDX_W  source register index
- cmd_dst  input  IDX_W  destination register index
- cmd_const  input  WIDTH  constant for LOAD_CONST
- reg_in  output  NUM_REGS  one-hot register load enables
- reg_out  output  NUM_REGS  one-hot register bus-drive enables
- tmp_in  output  1  TMP register load enable
- tmp_out  output  1  TMP register bus-drive enable
- const_en  output  1  selects const_val onto register D inputs
- const_val  output  WIDTH  latched constant
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle error pulse, coincident with done

Behaviour:
- All outputs registered. Reset (async) forces: state IDLE, reg_in=0, reg_out=0, tmp_in=0, tmp_out=0, const_en=0, const_val=0, done=0, err=0. cmd_ready=1 in IDLE, including the first cycle after reset deasserts.
- Accept: cmd_valid & cmd_ready at a rising edge. cmd_ready=0 in every non-IDLE state. Command fields are latched at accept; later changes are ignored.
- States: IDLE, STEP1, STEP2, STEP3.
- Each step asserts its enables for exactly one cycle. Registers capture on the rising edge that ends that cycle.
- MOVE: STEP1: reg_out[src]=1, reg_in[dst]=1. Then IDLE.
- LOAD_CONST: STEP1: const_en=1, const_val=cmd_const, reg_in[dst]=1. reg_out=0. Then IDLE. cmd_src is ignored.
- SWAP: STEP1: reg_out[src], tmp_in. STEP2: reg_out[dst], reg_in[src]. STEP3: tmp_out, reg_in[dst]. Then IDLE.
- Completion: on the edge leaving the last step, the controller enters IDLE with done=1 for one cycle and cmd_ready=1 in that same cycle.
- Latency: accept at edge k; done is high during cycle k+N+... i.e. after N step cycles (MOVE/LOAD N=1, SWAP N=3).
- Back-to-back: a command may be accepted in the done cycle, so MOVE throughput is 1 per 2 cycles.
- Single-driver invariant: at most one of {any reg_out bit, tmp_out, const_en} is high in any cycle. reg_in and reg_out are each one-hot or zero.
- Error cases, checked at accept: index ≥ NUM_REGS in a used field, or op=11. Response: no step cycles; next cycle is IDLE with done=1, err=1, all enables 0.
- Degenerate: MOVE or SWAP with src==dst is a no-op. It completes like an error (done next cycle, no enables) but with err=0.
- LOAD_CONST ignores the src==dst rule.
- const_val holds its last loaded value; it is only meaningful while const_en=1.
- Reset asserted mid-command: enables drop asynchronously and the command is abandoned with no done pulse. A partially completed SWAP leaves the register contents undefined and is not retried.

Test Plan:
- Reset, LOAD_CONST dst=0 const=50 -> one cycle with const_en=1, reg_in=0x01. Next cycle done=1. R0=50 in the bench register model.
- MOVE src=0 dst=1 after R0=50 -> one cycle with reg_out=0x01, reg_in=0x02. R1=50, done pulse, cmd_ready back to 1.
- R0=70, R1=50, SWAP src=0 dst=1 -> three step cycles with the specified enables. Final R0=50, R1=70. done 4 cycles after accept. The single-driver assertion holds every cycle.
- MOVE src=9 (NUM_REGS=8), then op=11 -> each produces done=1, err=1 the next cycle, with all enables 0 throughout.
- MOVE src=3 dst=3 -> done=1, err=0 the next cycle, no enables asserted. A follow-on command accepted in the done cycle executes normally.
- Start SWAP 2↔5, assert reset during STEP2 -> all enables 0 immediately, no done pulse. cmd_ready=1 after release, and a new LOAD_CONST completes correctly.
